// File: rtl/data_mem_responder.sv
// Multi-cycle data memory slave for the MEM-stage load/store port.
// Accepts one request at a time, stalls the pipeline, and pulses Done LATENCY cycles after acceptance.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  SEMCtrl,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        ErrMisaligned
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_next;

  logic [3:0]    count;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          write_q;

  logic          request;
  logic [AW-1:0] act_addr;
  logic [31:0]   act_wdata;
  logic [1:0]    act_size;
  logic          act_write;
  logic          act_mis;
  logic [ADDR_WIDTH-1:0] act_idx;
  logic [31:0]   word_rd;
  logic [31:0]   lane_rd;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic          load_capture;
  logic          store_commit;
  logic          unused_addr;

  assign request     = MemRead | MemWrite;
  assign unused_addr = ^Address[31:AW];

  // In IDLE the live inputs describe the request (needed when LATENCY=1 jumps
  // straight to RESP); afterwards the captured copy is authoritative.
  always_comb begin
    if (state == IDLE) begin
      act_addr  = Address[AW-1:0];
      act_wdata = WriteData;
      act_size  = SEMCtrl;
      act_write = MemWrite;
    end else begin
      act_addr  = addr_q;
      act_wdata = wdata_q;
      act_size  = size_q;
      act_write = write_q;
    end
  end

  assign act_idx = act_addr[AW-1:2];
  assign word_rd = mem[act_idx];

  always_comb begin
    act_mis     = 1'b0;
    lane_rd     = word_rd;
    byte_en     = 4'b1111;
    wdata_lanes = act_wdata;
    case (act_size)
      2'b01: begin
        act_mis     = act_addr[0];
        lane_rd     = act_addr[1] ? {16'b0, word_rd[31:16]} : {16'b0, word_rd[15:0]};
        byte_en     = act_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{act_wdata[15:0]}};
      end
      2'b10: begin
        case (act_addr[1:0])
          2'd0:    lane_rd = {24'b0, word_rd[7:0]};
          2'd1:    lane_rd = {24'b0, word_rd[15:8]};
          2'd2:    lane_rd = {24'b0, word_rd[23:16]};
          default: lane_rd = {24'b0, word_rd[31:24]};
        endcase
        byte_en     = 4'b0001 << act_addr[1:0];
        wdata_lanes = {4{act_wdata[7:0]}};
      end
      default: begin
        act_mis = (act_addr[1:0] != 2'b00);
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && request) begin
        count <= 4'(LATENCY - 1);
      end else if (state == BUSY) begin
        count <= count - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (request) begin
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (count <= 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Stall         = !Reset && ((state == IDLE && request) || state == BUSY);
    Done          = !Reset && (state == RESP);
    ErrMisaligned = !Reset && (state == RESP) && act_mis;
  end

  always_ff @(posedge Clk) begin
    if (state == IDLE && request) begin
      addr_q  <= Address[AW-1:0];
      wdata_q <= WriteData;
      size_q  <= SEMCtrl;
      write_q <= MemWrite;
    end
  end

  // Load data is registered on the edge entering RESP so it is valid alongside Done.
  assign load_capture = !Reset && (state != RESP) && (state_next == RESP) && !act_write;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ReadData <= '0;
    end else if (load_capture) begin
      ReadData <= act_mis ? '0 : lane_rd;
    end
  end

  assign store_commit = !Reset && (state == RESP) && act_write && !act_mis;

  always_ff @(posedge Clk) begin
    if (store_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[act_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances checked against a byte-array memory model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst   [2];
  logic        mr    [2];
  logic        mw    [2];
  logic [31:0] ad    [2];
  logic [31:0] wdt   [2];
  logic [1:0]  sz_in [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        done  [2];
  logic        err   [2];

  logic [7:0]  mm      [2][4096];
  logic [31:0] last_rd [2];
  int          n_cmp;
  int          n_bad;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .Clk(clk), .Reset(rst[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
    .Address(ad[0]), .WriteData(wdt[0]), .SEMCtrl(sz_in[0]),
    .ReadData(rdata[0]), .Stall(stall[0]), .Done(done[0]), .ErrMisaligned(err[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
    .Clk(clk), .Reset(rst[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
    .Address(ad[1]), .WriteData(wdt[1]), .SEMCtrl(sz_in[1]),
    .ReadData(rdata[1]), .Stall(stall[1]), .Done(done[1]), .ErrMisaligned(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input int b, input logic [1:0] sz);
    case (sz)
      2'b01:   return {16'b0, mm[d][b+1], mm[d][b]};
      2'b10:   return {24'b0, mm[d][b]};
      default: return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
    endcase
  endfunction

  task automatic model_write(input int d, input int b, input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b01: begin mm[d][b] = wd[7:0]; mm[d][b+1] = wd[15:8]; end
      2'b10: mm[d][b] = wd[7:0];
      default: begin
        mm[d][b] = wd[7:0]; mm[d][b+1] = wd[15:8];
        mm[d][b+2] = wd[23:16]; mm[d][b+3] = wd[31:24];
      end
    endcase
  endtask

  // One complete transaction: expectations come from the model before the DUT acts.
  task automatic run_req(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz);
    int          lat;
    int          b;
    logic        mis;
    logic [31:0] exp_rd;
    lat = (d == 0) ? 2 : 1;
    b   = int'(addr[11:0]);
    if (sz == 2'b01)      mis = addr[0];
    else if (sz == 2'b10) mis = 1'b0;
    else                  mis = (addr[1:0] != 2'b00);
    if (wr)       exp_rd = last_rd[d];
    else if (mis) exp_rd = 32'h0;
    else          exp_rd = model_read(d, b, sz);

    @(posedge clk); #1;
    mr[d] = rd; mw[d] = wr; ad[d] = addr; wdt[d] = wd; sz_in[d] = sz;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check_eq("stall_busy", 32'(stall[d]), 32'd1);
        check_eq("done_early", 32'(done[d]), 32'd0);
      end else begin
        check_eq("done_pulse", 32'(done[d]), 32'd1);
        check_eq("stall_resp", 32'(stall[d]), 32'd0);
        check_eq("err_misalign", 32'(err[d]), 32'(mis));
        check_eq("read_data", rdata[d], exp_rd);
      end
    end
    @(posedge clk); #1;
    mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = $urandom; wdt[d] = $urandom;
    if (wr && !mis) model_write(d, b, sz, wd);
    last_rd[d] = exp_rd;
  endtask

  initial begin
    logic [31:0] addr;
    int          op;
    n_cmp = 0;
    n_bad = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mr[d] = 1'b0; mw[d] = 1'b0;
      ad[d] = '0; wdt[d] = '0; sz_in[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      check_eq("reset_rdata", rdata[d], 32'h0);
      check_eq("reset_stall", 32'(stall[d]), 32'd0);
      check_eq("reset_done", 32'(done[d]), 32'd0);
      check_eq("reset_err", 32'(err[d]), 32'd0);
    end

    // Define the first 64 words of each memory so the model knows every value read back.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++)
        run_req(d, 1'b0, 1'b1, 32'(w * 4), $urandom, 2'b00);

    run_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00);
    run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b00);
    check_eq("roundtrip_word", rdata[0], 32'hDEADBEEF);

    run_req(0, 1'b0, 1'b1, 32'h20, 32'h0, 2'b00);
    run_req(0, 1'b0, 1'b1, 32'h22, 32'h000000AB, 2'b10);
    run_req(0, 1'b0, 1'b1, 32'h20, 32'h00001234, 2'b01);
    run_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00);
    check_eq("lanes_word", rdata[0], 32'h00AB1234);
    run_req(0, 1'b1, 1'b0, 32'h22, 32'h0, 2'b10);
    check_eq("lanes_byte", rdata[0], 32'h000000AB);
    run_req(0, 1'b1, 1'b0, 32'h22, 32'h0, 2'b01);
    check_eq("lanes_half", rdata[0], 32'h000000AB);

    run_req(0, 1'b1, 1'b0, 32'h21, 32'h0, 2'b00);
    check_eq("mis_load_zero", rdata[0], 32'h0);
    run_req(0, 1'b0, 1'b1, 32'h23, 32'h0000FFFF, 2'b01);
    run_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00);
    check_eq("mis_no_write", rdata[0], 32'h00AB1234);

    run_req(0, 1'b0, 1'b1, 32'h00001004, 32'h00000055, 2'b00);
    run_req(0, 1'b1, 1'b0, 32'h00000004, 32'h0, 2'b00);
    check_eq("wrap_read", rdata[0], 32'h00000055);

    run_req(0, 1'b0, 1'b1, 32'h30, 32'h13572468, 2'b00);
    @(posedge clk); #1;
    mw[0] = 1'b1; ad[0] = 32'h30; wdt[0] = 32'hFFFFFFFF; sz_in[0] = 2'b00;
    @(negedge clk);
    check_eq("abort_stall_c0", 32'(stall[0]), 32'd1);
    @(posedge clk); #1;
    rst[0] = 1'b1; mw[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_done_c1", 32'(done[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    last_rd[0] = 32'h0;
    @(negedge clk);
    check_eq("abort_stall_after", 32'(stall[0]), 32'd0);
    check_eq("abort_done_after", 32'(done[0]), 32'd0);
    check_eq("abort_rdata_cleared", rdata[0], 32'h0);
    @(negedge clk);
    check_eq("abort_done_late", 32'(done[0]), 32'd0);
    run_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 2'b00);
    check_eq("abort_prior_value", rdata[0], 32'h13572468);

    run_req(1, 1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 2'b00);
    @(posedge clk); #1;
    mr[1] = 1'b1; ad[1] = 32'h44; sz_in[1] = 2'b00;
    @(negedge clk);
    check_eq("b2b_stall_c0", 32'(stall[1]), 32'd1);
    check_eq("b2b_done_c0", 32'(done[1]), 32'd0);
    @(negedge clk);
    check_eq("b2b_done_c1", 32'(done[1]), 32'd1);
    check_eq("b2b_rdata_c1", rdata[1], 32'hCAFEF00D);
    @(negedge clk);
    check_eq("b2b_done_c2", 32'(done[1]), 32'd0);
    check_eq("b2b_stall_c2", 32'(stall[1]), 32'd1);
    @(negedge clk);
    check_eq("b2b_done_c3", 32'(done[1]), 32'd1);
    check_eq("b2b_rdata_c3", rdata[1], 32'hCAFEF00D);
    @(posedge clk); #1;
    mr[1] = 1'b0;
    last_rd[1] = 32'hCAFEF00D;
    @(negedge clk);
    check_eq("b2b_done_c4", 32'(done[1]), 32'd0);

    run_req(1, 1'b1, 1'b1, 32'h40, 32'h00000077, 2'b00);
    check_eq("rw_keeps_rdata", rdata[1], 32'hCAFEF00D);
    run_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00);
    check_eq("rw_stored", rdata[1], 32'h00000077);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        op   = int'($urandom_range(0, 3));
        addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2)
               | 32'($urandom_range(0, 3));
        run_req(d, (op != 2), (op >= 2), addr, $urandom, 2'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
